// File: rtl/fifo_burst_pkg.sv
// Shared types and default widths for the FIFO burst reader.
package fifo_burst_pkg;

  localparam int C_DATA_WIDTH_DEF = 64;
  localparam int C_LEN_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/fifo_burst_skid.sv
// Two-entry valid/ready register slice; in_ready depends only on local state,
// so no combinational ready path crosses it. Used when FIFO_BURST_READER_SKID_EN is defined.
module fifo_burst_skid #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload,
  output logic         empty
);

  logic [W-1:0] main_reg;
  logic [W-1:0] skid_reg;
  logic         main_valid_reg;
  logic         skid_valid_reg;

  // The skid entry only fills when the output is stalled; it refills the
  // output register first whenever the output frees up.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (out_ready || !main_valid_reg) begin
      if (skid_valid_reg) begin
        main_reg       <= skid_reg;
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        main_reg       <= in_payload;
        main_valid_reg <= in_valid;
      end
    end else if (in_valid && !skid_valid_reg) begin
      skid_reg       <= in_payload;
      skid_valid_reg <= 1'b1;
    end
  end

  assign in_ready    = !skid_valid_reg;
  assign out_valid   = main_valid_reg;
  assign out_payload = main_reg;
  assign empty       = !main_valid_reg && !skid_valid_reg;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops cmd_len+1 words from a valid/ready FIFO and emits them as a framed burst.
// Define FIFO_BURST_READER_SKID_EN for a registered 2-entry skid output path.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
  parameter int C_LEN_WIDTH  = C_LEN_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [C_LEN_WIDTH-1:0]  cmd_len,
  input  logic                    fifo_read_valid,
  output logic                    fifo_read_ready,
  input  logic [C_DATA_WIDTH-1:0] fifo_read_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [C_DATA_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  state_t                 state_reg, state_next;
  logic [C_LEN_WIDTH-1:0] remaining_reg, remaining_next;
  logic                   done_reg;
  logic                   pop;
  logic                   last_out;
  logic                   drain_exit;

  assign pop      = fifo_read_valid && fifo_read_ready;
  assign last_out = out_valid && out_ready && out_last;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;

`ifdef FIFO_BURST_READER_SKID_EN
  localparam state_t ST_AFTER_LAST = ST_DRAIN;

  logic                    skid_in_ready;
  logic                    skid_empty;
  logic [C_DATA_WIDTH:0]   skid_out;

  // Holding off pops during reset keeps unread words in the FIFO.
  assign fifo_read_ready = (state_reg == ST_XFER) && skid_in_ready && !reset;

  fifo_burst_skid #(
    .W (C_DATA_WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (pop),
    .in_ready    (skid_in_ready),
    .in_payload  ({remaining_reg == '0, fifo_read_data}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (skid_out),
    .empty       (skid_empty)
  );

  assign out_last   = skid_out[C_DATA_WIDTH];
  assign out_data   = skid_out[C_DATA_WIDTH-1:0];
  assign drain_exit = last_out || skid_empty;
`else
  localparam state_t ST_AFTER_LAST = ST_IDLE;

  // Zero-latency path: FIFO head is the output beat, ready flows straight back.
  assign fifo_read_ready = (state_reg == ST_XFER) && out_ready && !reset;
  assign out_valid       = (state_reg == ST_XFER) && fifo_read_valid && !reset;
  assign out_data        = fifo_read_data;
  assign out_last        = (state_reg == ST_XFER) && (remaining_reg == '0);
  assign drain_exit      = 1'b1;
`endif

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    cmd_ready      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          remaining_next = cmd_len;
          state_next     = ST_XFER;
        end
      end
      ST_XFER: begin
        // Stops at zero instead of wrapping, so a max-length burst ends cleanly.
        if (pop) begin
          if (remaining_reg == '0) begin
            state_next = ST_AFTER_LAST;
          end else begin
            remaining_next = remaining_reg - C_LEN_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_exit) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      done_reg      <= last_out;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed + randomized bench for fifo_burst_reader against a stream-level burst model.
module tb_fifo_burst_reader;

  localparam int DW = 64;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          fifo_read_valid;
  logic          fifo_read_ready;
  logic [DW-1:0] fifo_read_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  fifo_burst_reader #(
    .C_DATA_WIDTH (DW),
    .C_LEN_WIDTH  (LW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_len         (cmd_len),
    .fifo_read_valid (fifo_read_valid),
    .fifo_read_ready (fifo_read_ready),
    .fifo_read_data  (fifo_read_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // FIFO contents, every word ever written, and the bursts still owed downstream.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] stream[$];
  int            burst_q[$];
  int            next_idx = 0;
  int            beat_idx = 0;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  int beats = 0;
  int dones = 0;
  int cycle = 0;
  int last_beat_cycle = -10;
  int ready_mode = 0;
  int phase = 0;
  bit cmd_hs = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic refresh_fifo();
    fifo_read_valid = (fifo_q.size() != 0);
    fifo_read_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom(), $urandom()};
      stream.push_back(w);
      fifo_q.push_back(w);
    end
    refresh_fifo();
  endtask

  // One clock: sample at the falling edge, apply model updates after the rising edge.
  task automatic tick();
    bit pop_s;
    bit beat_s;
    @(negedge clk);
    pop_s  = fifo_read_valid && fifo_read_ready;
    beat_s = out_valid && out_ready;
    cmd_hs = cmd_valid && cmd_ready;
    if (prev_stall && !reset) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", out_data, prev_data);
      check("stall_last", 64'(out_last), 64'(prev_last));
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_data  = out_data;
    prev_last  = out_last;
    if (done) begin
      dones++;
      check("done_timing", 64'(cycle - last_beat_cycle), 64'd1);
    end
    if (beat_s) begin
      beats++;
      check("beat_expected", 64'(burst_q.size() != 0), 64'd1);
      if (burst_q.size() != 0 && next_idx < stream.size()) begin
        check("beat_data", out_data, stream[next_idx]);
        check("beat_last", 64'(out_last), 64'(beat_idx == burst_q[0]));
        next_idx++;
        if (beat_idx == burst_q[0]) begin
          void'(burst_q.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
      if (out_last) last_beat_cycle = cycle;
    end
    @(posedge clk);
    cycle++;
    if (pop_s) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    #1;
    refresh_fifo();
    case (ready_mode)
      1:       out_ready = ((phase % 3) == 0);
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
    phase++;
    #1;
  endtask

  task automatic send_cmd(input int len);
    int n;
    burst_q.push_back(len);
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cmd_hs && n < 50);
    cmd_valid = 1'b0;
    check("cmd_accept", 64'(cmd_hs), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = dones;
    n = 0;
    while (dones == d0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 64'(dones - d0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int b0;
    int d0;
    int len;
    int n;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    out_ready = 1'b1;
    refresh_fifo();

    // Reset state and idle behaviour with words waiting in the FIFO.
    repeat (3) tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_fifo_ready", 64'(fifo_read_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    push_words(3);
    repeat (4) tick();
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_pops", 64'(pops), 64'd0);
    check("idle_fifo_level", 64'(fifo_q.size()), 64'd3);

    // cmd_len=3 over A0..A3 with out_ready held high.
    push_words(1);
    p0 = pops;
    send_cmd(3);
    wait_done(40);
    check("b4_pops", 64'(pops - p0), 64'd4);
    check("b4_fifo_empty", 64'(fifo_q.size()), 64'd0);
    check("b4_all_beats", 64'(burst_q.size()), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);

    // Short burst leaves the rest in the FIFO; the next burst drains it.
    push_words(5);
    p0 = pops;
    send_cmd(1);
    wait_done(40);
    check("b2_pops", 64'(pops - p0), 64'd2);
    check("b2_fifo_left", 64'(fifo_q.size()), 64'd3);
    send_cmd(2);
    wait_done(40);
    check("b3_pops", 64'(pops - p0), 64'd5);
    check("b3_fifo_empty", 64'(fifo_q.size()), 64'd0);

    // Backpressure 1,0,0 repeating during an 8-beat burst.
    ready_mode = 1;
    phase = 0;
    push_words(8);
    p0 = pops;
    send_cmd(7);
    wait_done(100);
    check("bp_pops", 64'(pops - p0), 64'd8);
    check("bp_all_beats", 64'(burst_q.size()), 64'd0);
    ready_mode = 0;

    // FIFO underrun mid-burst: stall, then complete when data arrives.
    push_words(2);
    p0 = pops;
    d0 = dones;
    send_cmd(4);
    repeat (10) tick();
    check("ur_stall_pops", 64'(pops - p0), 64'd2);
    check("ur_stall_busy", 64'(busy), 64'd1);
    check("ur_no_done", 64'(dones - d0), 64'd0);
    push_words(3);
    wait_done(40);
    repeat (3) tick();
    check("ur_pops", 64'(pops - p0), 64'd5);
    check("ur_done_once", 64'(dones - d0), 64'd1);

    // Randomized lengths and downstream readiness, ending with the maximum burst.
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      len = (k == 7) ? 255 : $urandom_range(0, 20);
      push_words(len + 1);
      p0 = pops;
      send_cmd(len);
      wait_done(8 * (len + 1) + 40);
      check("rnd_pops", 64'(pops - p0), 64'(len + 1));
      check("rnd_all_beats", 64'(burst_q.size()), 64'd0);
    end
    ready_mode = 0;
    repeat (2) tick();

    // Reset after beat 2 of a 6-beat burst with 5 words available.
    push_words(5);
    p0 = pops;
    b0 = beats;
    d0 = dones;
    send_cmd(5);
    n = 0;
    while ((beats - b0) < 2 && n < 30) begin
      tick();
      n++;
    end
    check("mr_two_beats", 64'(beats - b0), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    burst_q.delete();
    beat_idx = 0;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mr_pops", 64'(pops - p0), 64'd2);
    check("mr_fifo_left", 64'(fifo_q.size()), 64'd3);
    repeat (3) tick();
    check("mr_no_done", 64'(dones - d0), 64'd0);
    send_cmd(2);
    wait_done(40);
    check("mr_drain_empty", 64'(fifo_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
